// File: rtl/mips_pkg.sv
// Shared fetch-queue types and defaults.
// Used by fetch_queue and fq_store.
package mips_pkg;

  localparam int unsigned FQ_DEPTH = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_store.sv
// Fetch-queue entry storage: DEPTH x 64-bit register file.
// Synchronous write, asynchronous read, no reset on data.
module fq_store
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  fq_entry_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output fq_entry_t                rdata_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue with redirect flush.
// Optional same-cycle bypass when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [10:0]                im_addr,
  input  logic [31:0]                im_instr,
  input  logic                       deq,
  output logic                       valid,
  output logic [31:0]                instr,
  output logic [31:0]                pc,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fpc_q, fpc_d;

  logic      empty, is_full;
  logic      deq_hit, enq, bypass;
  fq_entry_t wr_ent, rd_ent;

  assign empty   = (cnt_q == '0);
  assign is_full = (cnt_q == CW'(DEPTH));
  assign deq_hit = deq & ~empty & ~redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & ~redirect & deq;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed fetch is consumed directly and never stored.
  assign enq = ~redirect & (~is_full | deq_hit) & ~bypass;

  assign wr_ent.pc    = fpc_q;
  assign wr_ent.instr = im_instr;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    fpc_d  = fpc_q;
    if (redirect) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      fpc_d  = redirect_pc;
    end else begin
      if (deq_hit) head_d = head_q + PW'(1);
      if (enq) tail_d = tail_q + PW'(1);
      if (enq | bypass) fpc_d = fpc_q + 32'd4;
      cnt_d = cnt_q + CW'(enq) - CW'(deq_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      fpc_q  <= RESET_PC;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      fpc_q  <= fpc_d;
    end
  end

  fq_store #(.DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (tail_q),
    .wdata_i (wr_ent),
    .raddr_i (head_q),
    .rdata_o (rd_ent)
  );

  assign im_addr = fpc_q[12:2];
  assign full    = is_full;
  assign count   = cnt_q;

  always_comb begin
    valid = ~empty;
    instr = empty ? 32'h0 : rd_ent.instr;
    pc    = empty ? 32'h0 : rd_ent.pc;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && !redirect) begin
      valid = 1'b1;
      instr = im_instr;
      pc    = fpc_q;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized checks of fetch_queue against a queue model.
// Targets the default build (bypass disabled).
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, redirect, deq;
  logic [31:0] redirect_pc;
  logic [10:0] im_addr;
  logic [31:0] im_instr;
  logic        valid, full;
  logic [31:0] instr, pc;
  logic [2:0]  count;

  logic [31:0] mem [2048];
  assign im_instr = mem[im_addr];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_addr     (im_addr),
    .im_instr    (im_instr),
    .deq         (deq),
    .valid       (valid),
    .instr       (instr),
    .pc          (pc),
    .full        (full),
    .count       (count)
  );

  // Reference: program-order queue of {pc, instr} plus fetch pointer.
  logic [31:0] mq_pc [$];
  logic [31:0] mq_in [$];
  logic [31:0] mfpc;

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_edge();
    int sz;
    bit dh;
    sz = mq_pc.size();
    if (reset) begin
      mq_pc.delete(); mq_in.delete(); mfpc = RPC;
    end else if (redirect) begin
      mq_pc.delete(); mq_in.delete(); mfpc = redirect_pc;
    end else begin
      dh = deq && sz > 0;
      if (dh) begin
        void'(mq_pc.pop_front()); void'(mq_in.pop_front());
      end
      if (sz < DEPTH || dh) begin
        mq_pc.push_back(mfpc);
        mq_in.push_back(mem[mfpc[12:2]]);
        mfpc = mfpc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq_pc.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
    chk({tag, ".valid"}, 32'(valid), 32'(sz != 0));
    chk({tag, ".pc"}, pc, sz != 0 ? mq_pc[0] : 32'h0);
    chk({tag, ".instr"}, instr, sz != 0 ? mq_in[0] : 32'h0);
    chk({tag, ".im_addr"}, 32'(im_addr), 32'(mfpc[12:2]));
  endtask

  task automatic step(input logic r, input logic rd,
                      input logic [31:0] rp, input logic d,
                      input string tag);
    reset = r; redirect = rd; redirect_pc = rp; deq = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    #3;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
    mfpc = RPC;
    #2;

    step(1, 0, 0, 0, "rst0");
    step(1, 1, 32'h100, 1, "rst1");

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "fill");
    chk("fill.cnt4", 32'(count), 32'd4);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.pc", pc, 32'h3000);
    chk("fill.imaddr", 32'(im_addr), 32'h404);

    step(0, 0, 0, 1, "fdq0");
    chk("fdq.pc0", pc, 32'h3004);
    step(0, 0, 0, 1, "fdq1");
    chk("fdq.pc1", pc, 32'h3008);
    step(0, 0, 0, 1, "fdq2");
    chk("fdq.pc2", pc, 32'h300C);
    chk("fdq.cnt", 32'(count), 32'd4);

    step(0, 1, 32'h3200, 0, "flush");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "to3");
    chk("to3.cnt", 32'(count), 32'd3);
    step(0, 1, 32'h3400, 1, "redir");
    chk("redir.cnt", 32'(count), 32'd0);
    chk("redir.valid", 32'(valid), 32'd0);
    step(0, 0, 0, 0, "redir1");
    chk("redir1.pc", pc, 32'h3400);

    step(0, 1, 32'h3800, 0, "empty");
    step(0, 0, 0, 1, "udeq");
    chk("udeq.cnt", 32'(count), 32'd1);
    chk("udeq.pc", pc, 32'h3800);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] prev;
      prev = pc;
      step(0, 0, 0, 1'(i & 1), "alt");
      ntotal++;
      assert (count <= 3'd4 && (i % 2 == 0 || pc == prev + 32'd4)) npass++;
      else $error("FAIL alt.seq observed=cnt%0d pc%h expected=pc%h",
                  count, pc, prev + 32'd4);
    end

    step(0, 1, 32'h3600, 0, "pre38");
    step(0, 0, 0, 0, "c1");
    step(0, 0, 0, 0, "c2");
    chk("c2.cnt", 32'(count), 32'd2);
    step(1, 0, 0, 1, "midrst");
    chk("midrst.cnt", 32'(count), 32'd0);
    chk("midrst.valid", 32'(valid), 32'd0);
    chk("midrst.imaddr", 32'(im_addr), 32'h400);

    for (int i = 0; i < 400; i++) begin
      logic r, rd, d;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 19) == 0);
      d  = $urandom_range(0, 1) == 1;
      rp = $urandom & 32'hFFFF_FFFC;
      step(r, rd, rp, d, "rnd");
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
